// File: rtl/conv_stream_host.sv
// Host-side stream endpoint for the 1-D convolution accelerator: buffers one input
// frame, replays it on the x stream, collects the y results and serves them for readback.
module conv_stream_host #(
    parameter  int N   = 96,
    parameter  int M   = 65,
    parameter  int T   = 16,
    localparam int L   = N - M + 1,
    localparam int RAW = (L > 1) ? $clog2(L) : 1
) (
    input  logic           clk,
    input  logic           reset_n,
    input  logic [T-1:0]   load_data,
    input  logic           load_valid,
    output logic           load_ready,
    output logic [T-1:0]   x_data,
    output logic           x_valid,
    input  logic           x_ready,
    input  logic [T-1:0]   y_data,
    input  logic           y_valid,
    output logic           y_ready,
    input  logic [RAW-1:0] rd_addr,
    output logic [T-1:0]   rd_data,
    output logic           done,
    input  logic           result_ack,
    output logic [15:0]    frame_cnt
);
    localparam int CW  = $clog2(N + 1);
    localparam int LCW = $clog2(L + 1);
    localparam int XAW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [2:0] {INIT, FILL, SEND, COLLECT, DONE} state_t;
    state_t state, state_nxt;

    logic [T-1:0]   x_mem   [0:N-1];
    logic [T-1:0]   res_mem [0:L-1];

    logic [CW-1:0]  load_cnt, send_cnt, issue_cnt;
    logic [LCW-1:0] coll_cnt;
    logic [T-1:0]   x_rd_q, pf_data;
    logic           rd_pend, pf_valid;
    logic           load_fire, x_fire, y_fire;
    logic           last_load, last_x, last_y, ack;
    logic           issue, out_take;
    logic [1:0]     occ_after;
    logic [31:0]    rd_addr_ext;

    assign load_ready = (state == FILL);
    assign y_ready    = (state == COLLECT);
    assign done       = (state == DONE);

    assign load_fire  = load_valid && load_ready;
    assign x_fire     = x_valid && x_ready;
    assign y_fire     = y_valid && y_ready;
    assign last_load  = load_fire && (load_cnt == CW'(N - 1));
    assign last_x     = x_fire && (send_cnt == CW'(N - 1));
    assign last_y     = y_fire && (coll_cnt == LCW'(L - 1));
    assign ack        = done && result_ack;

    // A read is issued only if, after this edge, the output register plus prefetch
    // slot hold at most one word; the in-flight word then always has a place to land.
    assign occ_after  = 2'(x_valid) + 2'(pf_valid) + 2'(rd_pend) - 2'(x_fire);
    assign issue      = (state == SEND) && (issue_cnt < CW'(N)) && (occ_after <= 2'd1);
    assign out_take   = !x_valid || x_fire;
    assign rd_addr_ext = 32'(rd_addr);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= INIT;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            INIT:    state_nxt = FILL;
            FILL:    if (last_load)  state_nxt = SEND;
            SEND:    if (last_x)     state_nxt = COLLECT;
            COLLECT: if (last_y)     state_nxt = DONE;
            DONE:    if (result_ack) state_nxt = FILL;
            default: state_nxt = INIT;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            load_cnt  <= '0;
            send_cnt  <= '0;
            issue_cnt <= '0;
            coll_cnt  <= '0;
            frame_cnt <= '0;
        end else begin
            if (ack)            load_cnt <= '0;
            else if (load_fire) load_cnt <= load_cnt + CW'(1);
            if (last_load) begin
                send_cnt  <= '0;
                issue_cnt <= '0;
            end else begin
                if (x_fire) send_cnt  <= send_cnt + CW'(1);
                if (issue)  issue_cnt <= issue_cnt + CW'(1);
            end
            if (ack)         coll_cnt <= '0;
            else if (y_fire) coll_cnt <= coll_cnt + LCW'(1);
            if (last_y) frame_cnt <= frame_cnt + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (load_fire) x_mem[load_cnt[XAW-1:0]] <= load_data;
        if (issue)     x_rd_q <= x_mem[issue_cnt[XAW-1:0]];
        if (y_fire)    res_mem[coll_cnt[RAW-1:0]] <= y_data;
    end

    // Output register refills from the prefetch slot first, so word order is kept.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_pend  <= 1'b0;
            x_valid  <= 1'b0;
            x_data   <= '0;
            pf_valid <= 1'b0;
            pf_data  <= '0;
        end else begin
            rd_pend <= issue;
            if (out_take) begin
                if (pf_valid) begin
                    x_data  <= pf_data;
                    x_valid <= 1'b1;
                end else if (rd_pend) begin
                    x_data  <= x_rd_q;
                    x_valid <= 1'b1;
                end else begin
                    x_valid <= 1'b0;
                end
            end
            if (pf_valid) begin
                if (out_take) begin
                    pf_valid <= rd_pend;
                    pf_data  <= x_rd_q;
                end
            end else if (rd_pend && !out_take) begin
                pf_valid <= 1'b1;
                pf_data  <= x_rd_q;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)                     rd_data <= '0;
        else if (rd_addr_ext < 32'(L))    rd_data <= res_mem[rd_addr];
        else                              rd_data <= '0;
    end

endmodule

// File: doc/conv_stream_host.md
# conv_stream_host

Host-side stream endpoint for the 1-D convolution accelerator (N-sample input, M-tap filter, L = N-M+1 outputs). It buffers one N-word input frame from a host write stream, then replays it on the accelerator's x valid/ready port at up to one word per cycle. It then accepts the L results from the accelerator's y valid/ready port into a result buffer and exposes that buffer to the host through a synchronous read port. It sits between the host/testbench fabric and the convolution core and completes both ends of that core's stream protocol.

## Interface
- N, 96, input frame length (words)
- M, 65, filter length; the block uses M only to derive L = N-M+1
- T, 16, word width (bits, two's complement)
- clk  in  1  rising-edge clock
- reset_n  in  1  asynchronous active-low reset
- load_data  in  T  host input word
- load_valid  in  1  host word valid
- load_ready  out  1  block accepts a host word
- x_data  out  T  word to the accelerator, registered
- x_valid  out  1  x_data valid, registered
- x_ready  in  1  accelerator accepts x_data
- y_data  in  T  accelerator result word
- y_valid  in  1  y_data valid
- y_ready  out  1  block accepts y_data
- rd_addr  in  $clog2(L)  result buffer read address
- rd_data  out  T  result word, registered
- done  out  1  result frame complete and readable (level)
- result_ack  in  1  host releases the results (single-cycle pulse)
- frame_cnt  out  16  count of completed frames, wraps at 2^16

## Operation
- Storage:
  - x buffer: N×T, synchronous read.
  - result buffer: L×T, synchronous read.
- Counters:
  - load_cnt, send_cnt: $clog2(N+1) bits.
  - coll_cnt: $clog2(L+1) bits.
- States: INIT, FILL, SEND, COLLECT, DONE.
- INIT:
  - Entered on reset.
  - Moves to FILL unconditionally on the first clock edge after reset_n deasserts.
- FILL:
  - load_ready=1.
  - Each load_valid&&load_ready handshake writes load_data to x[load_cnt] and increments load_cnt.
  - On the N-th handshake: go to SEND, clear send_cnt.
- SEND:
  - x[0..N-1] is driven in order on x_data.
  - x_data and x_valid come from an output register plus a one-entry prefetch slot, giving full throughput: back-to-back words on consecutive cycles while x_ready=1.
  - While x_valid=1 and x_ready=0, x_data must hold stable. No word may be dropped or duplicated.
  - On the N-th x handshake: x_valid falls next cycle; go to COLLECT.
- COLLECT:
  - y_ready=1.
  - Each y_valid&&y_ready handshake writes y_data to result[coll_cnt] and increments coll_cnt.
  - On the L-th handshake: go to DONE, and increment frame_cnt.
- DONE:
  - done=1; load_ready, x_valid and y_ready are all 0.
  - result_ack=1 moves to FILL and clears load_cnt and coll_cnt.
- result_ack in any state other than DONE is ignored.
- y_valid outside COLLECT is ignored (y_ready=0, nothing is written).
- Read port:
  - Active in every state except reset: rd_data <= result[rd_addr] each cycle.
  - Read while in COLLECT returns the current contents, which may be stale.
  - rd_addr ≥ L returns 0.
- Arithmetic: data is passed through unmodified; no saturation or sign handling.
- Buffer contents are not cleared by reset or by result_ack; their contents are undefined until written.

## Timing
- Reset (reset_n=0, asynchronous):
  - state=INIT.
  - load_ready=0, x_valid=0, x_data=0, y_ready=0, rd_data=0, done=0, frame_cnt=0; all counters 0.
  - Applies immediately, including mid-frame; the frame in progress is abandoned.
- load_ready, y_ready and done are decoded from state only; they do not depend combinationally on any input.
- FILL→SEND: x_valid first rises 2 cycles after the edge of the N-th load handshake (one cycle for the buffer read, one for the output register).
- SEND with x_ready held high: N consecutive x_valid cycles, then COLLECT entered the cycle after the last handshake.
- y_ready rises the first cycle of COLLECT.
- done rises the cycle after the L-th y handshake. frame_cnt updates on the same edge.
- rd_data latency: 1 cycle from rd_addr.
- done falls, and load_ready rises, the cycle after result_ack is sampled in DONE.
- Best-case frame turnaround with no stalls: N load cycles + (N+2) send cycles + L collect cycles + ack.

## Test plan
- Reset and INIT:
  - Stimulus: hold reset_n=0 for 3 cycles, release.
  - Required: all outputs 0 during reset; load_ready=1 starting the 2nd cycle after release.
- Full-throughput frame:
  - Stimulus: load words 0..95 with load_valid always 1; hold x_ready=1.
  - Required: x_data 0..95 on 96 consecutive x_valid cycles; then x_valid=0 and y_ready=1.
- Backpressure:
  - Stimulus: x_ready follows the pattern 1,0,0,1,0 repeating.
  - Required: x_data is stable whenever x_valid=1 and x_ready=0; the accepted sequence is exactly 0..95 with no gaps or repeats.
- Collection and readback:
  - Stimulus: send 32 y words with values 100..131, with y_valid gaps.
  - Required: done=1 the cycle after the 32nd handshake; frame_cnt=1; rd_addr=5 returns rd_data=105 one cycle later; rd_addr=31 returns 131.
- Ack and second frame:
  - Stimulus: pulse result_ack during SEND of frame 2, then again in DONE.
  - Required: the pulse during SEND is ignored. After the DONE ack: done=0 and load_ready=1 next cycle. The second frame completes with frame_cnt=2, and its results overwrite the first frame's.
- Reset mid-operation:
  - Stimulus: assert reset_n=0 after 40 x handshakes.
  - Required: x_valid=0 immediately (without waiting for a clock edge). After release, a fresh full frame processes correctly and frame_cnt restarts at 0→1.
